// File: rtl/decode_pipe_stage_pkg.sv
// ============================================================================
// Module : decode_pipe_stage_pkg
// Desc   : MIPS decode-stage constants: field positions, widths, sign extend.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package decode_pipe_stage_pkg;

   localparam int INSTR_W  = 32;
   localparam int OPCODE_W = 6;
   localparam int FIELD_W  = 5;
   localparam int IMM_W    = 16;

   localparam int OP_LSB   = 26;
   localparam int RS_LSB   = 21;
   localparam int RT_LSB   = 16;
   localparam int RD_LSB   = 11;
   localparam int IMM_LSB  = 0;

   localparam int REG0     = 0;

   localparam int WB_W_DEF        = 2;
   localparam int M_W_DEF         = 3;
   localparam int EX_W_DEF        = 4;
   localparam int MEMREAD_BIT_DEF = 1;

   function automatic logic [INSTR_W-1:0] sign_ext16(input logic [IMM_W-1:0] v);
      return {{(INSTR_W-IMM_W){v[IMM_W-1]}}, v};
   endfunction

endpackage

`default_nettype wire

// File: rtl/decode_pipe_stage_if.sv
// ============================================================================
// Module : decode_pipe_stage_if
// Desc   : Fetch, control-unit, register-file, write-back and ID/EX signals.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface decode_pipe_stage_if
   import decode_pipe_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = FIELD_W,
   parameter int WB_W   = WB_W_DEF,
   parameter int M_W    = M_W_DEF,
   parameter int EX_W   = EX_W_DEF
);
   logic [ADDR_W-1:0]   if_pc;
   logic [INSTR_W-1:0]  if_instr;
   logic                if_valid;
   logic                flush;
   logic [OPCODE_W-1:0] id_opcode;
   logic [WB_W-1:0]     ctrl_wb;
   logic [M_W-1:0]      ctrl_m;
   logic [EX_W-1:0]     ctrl_ex;
   logic [REG_AW-1:0]   rf_ra1;
   logic [REG_AW-1:0]   rf_ra2;
   logic [DATA_W-1:0]   rf_rd1;
   logic [DATA_W-1:0]   rf_rd2;
   logic                wb_we;
   logic [REG_AW-1:0]   wb_wa;
   logic [DATA_W-1:0]   wb_wd;
   logic                pc_write;
   logic                ex_valid;
   logic [WB_W-1:0]     ex_wb;
   logic [M_W-1:0]      ex_m;
   logic [EX_W-1:0]     ex_ex;
   logic [ADDR_W-1:0]   ex_pc;
   logic [DATA_W-1:0]   ex_rs_data;
   logic [DATA_W-1:0]   ex_rt_data;
   logic [INSTR_W-1:0]  ex_imm;
   logic [REG_AW-1:0]   ex_rs;
   logic [REG_AW-1:0]   ex_rt;
   logic [REG_AW-1:0]   ex_rd;

   modport master (
      output if_pc, if_instr, if_valid, flush,
      output ctrl_wb, ctrl_m, ctrl_ex, rf_rd1, rf_rd2,
      output wb_we, wb_wa, wb_wd,
      input  id_opcode, rf_ra1, rf_ra2, pc_write,
      input  ex_valid, ex_wb, ex_m, ex_ex, ex_pc,
      input  ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
   );

   modport slave (
      input  if_pc, if_instr, if_valid, flush,
      input  ctrl_wb, ctrl_m, ctrl_ex, rf_rd1, rf_rd2,
      input  wb_we, wb_wa, wb_wd,
      output id_opcode, rf_ra1, rf_ra2, pc_write,
      output ex_valid, ex_wb, ex_m, ex_ex, ex_pc,
      output ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd
   );

endinterface

`default_nettype wire

// File: rtl/decode_pipe_stage_hazard_detect.sv
// ============================================================================
// Module : hazard_detect
// Desc   : Load-use hazard: a load in ID/EX writes a register the ID instr reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_detect
   import decode_pipe_stage_pkg::*;
#(
   parameter int REG_AW = FIELD_W
)(
   input  logic              ifid_valid_i,
   input  logic              ex_valid_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   output logic              haz_o
);

   assign haz_o = ifid_valid_i && ex_valid_i && ex_memread_i &&
                  (ex_rt_i != REG_AW'(REG0)) &&
                  ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

`default_nettype wire

// File: rtl/decode_pipe_stage.sv
// ============================================================================
// Module : decode_pipe_stage
// Desc   : IF/ID + ID/EX registers with load-use stall, flush and bubbles.
//          Optional ID_WB_BYPASS_EN forwards write-back data into ID operands.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decode_pipe_stage
   import decode_pipe_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int REG_AW      = FIELD_W,
   parameter int WB_W        = WB_W_DEF,
   parameter int M_W         = M_W_DEF,
   parameter int EX_W        = EX_W_DEF,
   parameter int MEMREAD_BIT = MEMREAD_BIT_DEF
)(
   input  logic               clk,
   input  logic               rst,
   decode_pipe_stage_if.slave bus
);

   typedef struct packed {
      logic                valid;
      logic [WB_W-1:0]     wb;
      logic [M_W-1:0]      m;
      logic [EX_W-1:0]     ex;
      logic [ADDR_W-1:0]   pc;
      logic [DATA_W-1:0]   rs_data;
      logic [DATA_W-1:0]   rt_data;
      logic [INSTR_W-1:0]  imm;
      logic [REG_AW-1:0]   rs;
      logic [REG_AW-1:0]   rt;
      logic [REG_AW-1:0]   rd;
   } idex_t;

   logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic               ifid_valid_q, ifid_valid_d;
   idex_t              idex_q, idex_d;

   logic [REG_AW-1:0]  id_rs, id_rt, id_rd;
   logic [DATA_W-1:0]  op_a, op_b;
   logic               haz;

   assign id_rs = REG_AW'(ifid_instr_q[RS_LSB +: FIELD_W]);
   assign id_rt = REG_AW'(ifid_instr_q[RT_LSB +: FIELD_W]);
   assign id_rd = REG_AW'(ifid_instr_q[RD_LSB +: FIELD_W]);

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .ifid_valid_i (ifid_valid_q),
      .ex_valid_i   (idex_q.valid),
      .ex_memread_i (idex_q.m[MEMREAD_BIT]),
      .ex_rt_i      (idex_q.rt),
      .id_rs_i      (id_rs),
      .id_rt_i      (id_rt),
      .haz_o        (haz)
   );

`ifdef ID_WB_BYPASS_EN
   logic wb_hit_rs, wb_hit_rt;
   assign wb_hit_rs = bus.wb_we && (bus.wb_wa != REG_AW'(REG0)) && (bus.wb_wa == id_rs);
   assign wb_hit_rt = bus.wb_we && (bus.wb_wa != REG_AW'(REG0)) && (bus.wb_wa == id_rt);
   assign op_a      = wb_hit_rs ? bus.wb_wd : bus.rf_rd1;
   assign op_b      = wb_hit_rt ? bus.wb_wd : bus.rf_rd2;
`else
   // Register file resolves same-cycle write/read itself; write-back port unused.
   logic unused_wb;
   assign unused_wb = ^{bus.wb_we, bus.wb_wa, bus.wb_wd};
   assign op_a      = bus.rf_rd1;
   assign op_b      = bus.rf_rd2;
`endif

   // Priority: flush > hazard > normal advance (reset handled in the register).
   always_comb begin
      ifid_pc_d      = bus.if_pc;
      ifid_instr_d   = bus.if_instr;
      ifid_valid_d   = bus.if_valid;

      idex_d         = '0;
      idex_d.valid   = ifid_valid_q;
      idex_d.wb      = ifid_valid_q ? bus.ctrl_wb : '0;
      idex_d.m       = ifid_valid_q ? bus.ctrl_m  : '0;
      idex_d.ex      = ifid_valid_q ? bus.ctrl_ex : '0;
      idex_d.pc      = ifid_pc_q;
      idex_d.rs_data = op_a;
      idex_d.rt_data = op_b;
      idex_d.imm     = sign_ext16(ifid_instr_q[IMM_LSB +: IMM_W]);
      idex_d.rs      = id_rs;
      idex_d.rt      = id_rt;
      idex_d.rd      = id_rd;

      if (bus.flush) begin
         ifid_pc_d    = '0;
         ifid_instr_d = '0;
         ifid_valid_d = 1'b0;
         idex_d       = '0;
      end else if (haz) begin
         ifid_pc_d    = ifid_pc_q;
         ifid_instr_d = ifid_instr_q;
         ifid_valid_d = ifid_valid_q;
         idex_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_pc_q    <= '0;
         ifid_instr_q <= '0;
         ifid_valid_q <= 1'b0;
         idex_q       <= '0;
      end else begin
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         idex_q       <= idex_d;
      end
   end

   // Reset term keeps the PC enabled before the registers hold known values.
   assign bus.pc_write   = rst || !haz || bus.flush;

   assign bus.id_opcode  = ifid_instr_q[OP_LSB +: OPCODE_W];
   assign bus.rf_ra1     = id_rs;
   assign bus.rf_ra2     = id_rt;

   assign bus.ex_valid   = idex_q.valid;
   assign bus.ex_wb      = idex_q.wb;
   assign bus.ex_m       = idex_q.m;
   assign bus.ex_ex      = idex_q.ex;
   assign bus.ex_pc      = idex_q.pc;
   assign bus.ex_rs_data = idex_q.rs_data;
   assign bus.ex_rt_data = idex_q.rt_data;
   assign bus.ex_imm     = idex_q.imm;
   assign bus.ex_rs      = idex_q.rs;
   assign bus.ex_rt      = idex_q.rt;
   assign bus.ex_rd      = idex_q.rd;

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe_stage.sv
// ============================================================================
// Module : tb_decode_pipe_stage
// Desc   : Scoreboard bench for decode_pipe_stage (ID_WB_BYPASS_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_decode_pipe_stage;
   import decode_pipe_stage_pkg::*;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 32;
   localparam int REG_AW      = 5;
   localparam int WB_W        = 2;
   localparam int M_W         = 3;
   localparam int EX_W        = 4;
   localparam int MEMREAD_BIT = 1;

   localparam logic [31:0] ADDI8   = 32'h2008_FFFC;  // addi $8,$0,-4
   localparam logic [31:0] LW8     = 32'h8D28_0000;  // lw   $8,0($9)
   localparam logic [31:0] ADD8    = 32'h010B_5020;  // add  $10,$8,$11
   localparam logic [31:0] LW0     = 32'h8D20_0000;  // lw   $0,0($9)
   localparam logic [31:0] ADD0    = 32'h000B_5020;  // add  $10,$0,$11
   localparam logic [31:0] ADDI_P  = 32'h2009_7FFF;  // addi $9,$0,0x7fff
   localparam logic [31:0] SW_N    = 32'hAC89_8000;  // sw   $9,-32768($4)
   localparam logic [31:0] SUB3    = 32'h0022_1822;  // sub  $3,$1,$2
   localparam logic [31:0] LW5     = 32'h8CC5_FFFF;  // lw   $5,-1($6)

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [M_W-1:0]    m;
      logic [EX_W-1:0]   ex;
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] rsd;
      logic [DATA_W-1:0] rtd;
      logic [31:0]       imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   rec_t exp_q[$];
   rec_t obs_q[$];

   decode_pipe_stage_if #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
      .WB_W(WB_W), .M_W(M_W), .EX_W(EX_W)
   ) bus ();

   decode_pipe_stage #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
      .WB_W(WB_W), .M_W(M_W), .EX_W(EX_W), .MEMREAD_BIT(MEMREAD_BIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Control unit model: {wb, m, ex}; MemRead is m[1].
   function automatic logic [8:0] ctl(input logic [5:0] op);
      case (op)
         6'h23:   return {2'b11, 3'b010, 4'b0001};
         6'h2B:   return {2'b00, 3'b001, 4'b0001};
         6'h08:   return {2'b10, 3'b000, 4'b0010};
         6'h00:   return {2'b10, 3'b000, 4'b1100};
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [31:0] rf1(input logic [4:0] a);
      return 32'hA000_0000 | {27'd0, a};
   endfunction

   function automatic logic [31:0] rf2(input logic [4:0] a);
      return 32'hB000_0000 | {27'd0, a};
   endfunction

   function automatic rec_t mk_rec(input logic [31:0] pc, input logic [31:0] ins);
      rec_t       r;
      logic [8:0] c;
      c     = ctl(ins[31:26]);
      r.wb  = c[8:7];
      r.m   = c[6:4];
      r.ex  = c[3:0];
      r.pc  = pc;
      r.rs  = ins[25:21];
      r.rt  = ins[20:16];
      r.rd  = ins[15:11];
      r.rsd = rf1(ins[25:21]);
      r.rtd = rf2(ins[20:16]);
      r.imm = {{16{ins[15]}}, ins[15:0]};
      return r;
   endfunction

   assign {bus.ctrl_wb, bus.ctrl_m, bus.ctrl_ex} = ctl(bus.id_opcode);
   assign bus.rf_rd1 = rf1(bus.rf_ra1);
   assign bus.rf_rd2 = rf2(bus.rf_ra2);

   // Every valid ID/EX occupant is captured for in-order scoreboard comparison.
   always @(negedge clk) begin
      if (!rst && bus.ex_valid === 1'b1)
         obs_q.push_back(rec_t'({bus.ex_wb, bus.ex_m, bus.ex_ex, bus.ex_pc,
                                 bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
                                 bus.ex_rs, bus.ex_rt, bus.ex_rd}));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
      bus.if_pc    = pc;
      bus.if_instr = ins;
      bus.if_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid);
      end
      n_checks++;
      if ({bus.ex_wb, bus.ex_m, bus.ex_ex} !== 9'd0) begin
         n_fail++; $display("FAIL reset_ctrl: got %h want 000", {bus.ex_wb, bus.ex_m, bus.ex_ex});
      end
      n_checks++;
      if (bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL reset_pc_write: got %b want 1", bus.pc_write);
      end
      n_checks++;
      if (bus.ex_imm !== 32'd0 || bus.ex_pc !== 32'd0) begin
         n_fail++; $display("FAIL reset_data: imm %h pc %h want 0", bus.ex_imm, bus.ex_pc);
      end
      rst = 1'b0;
   endtask

   task automatic test_sign_extend();
      drive(32'h104, ADDI8);
      exp_q.push_back(mk_rec(32'h104, ADDI8));
      tick();
      bus.if_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_imm !== 32'hFFFF_FFFC || bus.ex_rt !== 5'd8) begin
         n_fail++;
         $display("FAIL addi_decode: valid %b imm %h rt %0d want 1 fffffffc 8",
                  bus.ex_valid, bus.ex_imm, bus.ex_rt);
      end
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0 || bus.ex_wb !== 2'd0) begin
         n_fail++; $display("FAIL invalid_ctrl_zero: valid %b wb %b want 0 00", bus.ex_valid, bus.ex_wb);
      end
   endtask

   task automatic test_load_use();
      drive(32'h200, LW8);
      exp_q.push_back(mk_rec(32'h200, LW8));
      tick();
      drive(32'h204, ADD8);
      exp_q.push_back(mk_rec(32'h204, ADD8));
      tick();
      n_checks++;
      if (bus.pc_write !== 1'b0) begin
         n_fail++; $display("FAIL load_use_stall: pc_write %b want 0", bus.pc_write);
      end
      bus.if_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0 || bus.ex_m !== 3'd0) begin
         n_fail++; $display("FAIL load_use_bubble: valid %b m %b want 0 000", bus.ex_valid, bus.ex_m);
      end
      n_checks++;
      if (bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL load_use_release: pc_write %b want 1", bus.pc_write);
      end
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd10 || bus.ex_rs !== 5'd8) begin
         n_fail++;
         $display("FAIL load_use_issue: valid %b rd %0d rs %0d want 1 10 8",
                  bus.ex_valid, bus.ex_rd, bus.ex_rs);
      end
   endtask

   task automatic test_reg0_no_stall();
      drive(32'h280, LW0);
      exp_q.push_back(mk_rec(32'h280, LW0));
      tick();
      drive(32'h284, ADD0);
      exp_q.push_back(mk_rec(32'h284, ADD0));
      tick();
      n_checks++;
      if (bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL reg0_pc_write: got %b want 1", bus.pc_write);
      end
      bus.if_valid = 1'b0;
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd10) begin
         n_fail++; $display("FAIL reg0_issue: valid %b rd %0d want 1 10", bus.ex_valid, bus.ex_rd);
      end
      tick();
   endtask

   task automatic test_flush_over_stall();
      drive(32'h300, LW8);
      exp_q.push_back(mk_rec(32'h300, LW8));
      tick();
      drive(32'h304, ADD8);
      tick();
      bus.flush = 1'b1;
      #1;
      n_checks++;
      if (bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL flush_pc_write: got %b want 1", bus.pc_write);
      end
      tick();
      bus.flush    = 1'b0;
      bus.if_valid = 1'b0;
      n_checks++;
      if (bus.ex_valid !== 1'b0 || {bus.ex_wb, bus.ex_m, bus.ex_ex} !== 9'd0) begin
         n_fail++; $display("FAIL flush_idex: valid %b ctrl %h want 0 000",
                            bus.ex_valid, {bus.ex_wb, bus.ex_m, bus.ex_ex});
      end
      tick();
      n_checks++;
      if (bus.ex_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_ifid: ex_valid %b want 0", bus.ex_valid);
      end
   endtask

   task automatic test_bypass();
      rec_t        r;
      logic [31:0] want;
`ifdef ID_WB_BYPASS_EN
      want = 32'h0000_1234;
`else
      want = rf1(5'd8);
`endif
      r     = mk_rec(32'h400, ADD8);
      r.rsd = want;
      drive(32'h400, ADD8);
      exp_q.push_back(r);
      tick();
      bus.if_valid = 1'b0;
      bus.wb_we    = 1'b1;
      bus.wb_wa    = 5'd8;
      bus.wb_wd    = 32'h0000_1234;
      tick();
      bus.wb_we    = 1'b0;
      n_checks++;
      if (bus.ex_rs_data !== want || bus.ex_rt_data !== rf2(5'd11)) begin
         n_fail++; $display("FAIL bypass_rs: rs_data %h rt_data %h want %h %h",
                            bus.ex_rs_data, bus.ex_rt_data, want, rf2(5'd11));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(32'h500, ADDI_P); exp_q.push_back(mk_rec(32'h500, ADDI_P)); tick();
      drive(32'h504, SW_N);   exp_q.push_back(mk_rec(32'h504, SW_N));   tick();
      drive(32'h508, SUB3);   exp_q.push_back(mk_rec(32'h508, SUB3));   tick();
      n_checks++;
      if (bus.ex_imm !== 32'hFFFF_8000 || bus.pc_write !== 1'b1) begin
         n_fail++; $display("FAIL b2b_neg_imm: imm %h pc_write %b want ffff8000 1",
                            bus.ex_imm, bus.pc_write);
      end
      drive(32'h50C, LW5);    exp_q.push_back(mk_rec(32'h50C, LW5));    tick();
      bus.if_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_scoreboard();
      rec_t e, o;
      @(negedge clk);
      #1;
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL sb_count: observed %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++; $display("FAIL sb_entry pc %h: got %h want %h", e.pc, o, e);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.if_pc    = '0;
      bus.if_instr = '0;
      bus.if_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.wb_we    = 1'b0;
      bus.wb_wa    = '0;
      bus.wb_wd    = '0;

      test_reset();
      test_sign_extend();
      test_load_use();
      test_reg0_no_stall();
      test_flush_over_stall();
      test_bypass();
      test_back_to_back();
      test_scoreboard();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
